pe_mac_stream: RTL and testbench
================================

// Module: pe_mac_stream
// PURPOSE
//   Processing-element MAC stage that sits directly upstream of psum_accumulator.
//   Consumes a valid/ready stream of signed activation/weight pairs and multiplies each pair.
//   Accumulates KLEN products per window, with saturation, and emits one 16-bit partial sum per window.
//   The emitted value is the psum_in word that the downstream accumulator consumes.
//   An output holding register lets the next window accumulate while the previous result waits for out_ready.
// PARAMETERS
//   DATA_W  8   width of signed act_in / wgt_in (two's complement)
//   PSUM_W  16  width of signed psum_out; must be >= 2*DATA_W
//   KLEN    3   products per window; must be >= 1
// PORTS
//   clk        in   1       single clock, all state updates on posedge
//   rst        in   1       synchronous, active-low reset (0 = reset, sampled on posedge clk)
//   in_valid   in   1       act_in/wgt_in valid
//   in_ready   out  1       stage can accept a beat this cycle
//   act_in     in   DATA_W  signed activation
//   wgt_in     in   DATA_W  signed weight
//   out_valid  out  1       psum_out/psum_sat hold a completed window
//   out_ready  in   1       downstream accepts psum_out this cycle
//   psum_out   out  PSUM_W  signed window sum, saturated
//   psum_sat   out  1       at least one saturation occurred in this window
// BEHAVIOUR
//   - Beat: in_valid && in_ready at posedge. Out-handshake: out_valid && out_ready at posedge.
//   - Reset (rst==0 at posedge): acc=0, cnt=0, sat_acc=0, out_valid=0, psum_out=0, psum_sat=0.
//   - in_ready is 0 while rst==0. Reset mid-window discards the partial sum and any held output.
//   - Datapath per beat:
//       prod = act_in*wgt_in, signed, 2*DATA_W bits.
//       sum = acc + sext(prod), computed at PSUM_W+1 bits.
//       sum > 2^(PSUM_W-1)-1 clamps to max; sum < -2^(PSUM_W-1) clamps to min.
//       Any clamp sets the window's sat bit.
//   - Counter cnt runs 0..KLEN-1 and counts accepted beats.
//   - Beat with cnt<KLEN-1: acc<=sum, sat_acc|=clamp, cnt++.
//   - Beat with cnt==KLEN-1 (window end):
//       psum_out<=sum, psum_sat<=sat_acc|clamp, out_valid<=1.
//       acc<=0, sat_acc<=0, cnt<=0.
//   - Latency: psum_out is valid the cycle after the KLEN-th beat's posedge.
//   - out_valid stays high and psum_out/psum_sat stay stable until an out-handshake.
//   - Out-handshake with no window-end beat in the same cycle: out_valid<=0.
//   - Same-cycle out-handshake and window-end beat: the new result loads and out_valid stays 1.
//   - in_ready = rst && !(out_valid && !out_ready && cnt==KLEN-1):
//       the stage stalls only when finishing a window would overwrite an unaccepted result.
//       Earlier beats of the next window are still accepted while the result is held.
//   - in_valid=0 cycles: no state change (bubbles allowed mid-window).
//   - KLEN==1: every beat is a window end; steady-state throughput is 1 beat/cycle while out_ready=1.
//   - in_ready depends combinationally on out_ready. There are no other combinational in->out paths.
// TESTING
//   1. KLEN=3, beats (2,5),(4,5),(6,5) back-to-back, out_ready=1
//      -> psum_out=60, psum_sat=0, out_valid for exactly 1 cycle, 1 cycle after beat 3.
//   2. Beats (127,127) x3 -> 16129+16129 = 32258, then +16129 clamps
//      -> psum_out=32767, psum_sat=1. Next window (1,1)x3 -> psum_out=3, psum_sat=0.
//   3. Beats (-128,127) x3 -> psum_out=-32768, psum_sat=1.
//      Mixed window (-3,4),(5,2),(0,9) -> psum_out=-2, psum_sat=0.
//   4. out_ready=0 after window 1 (=60):
//      -> psum_out holds 60; the next 2 beats are accepted; in_ready=0 at cnt==2.
//      Raise out_ready -> 60 accepted, the 3rd beat is taken the same cycle, next psum valid the following cycle.
//   5. rst=0 after 2 beats of a window, then (1,1)x3
//      -> all outputs are 0 during reset; post-reset psum_out=3 (no stale partial).
//   6. Random in_valid bubbles and out_ready throttling over 200 windows
//      -> output sequence matches a saturating reference model; no lost or duplicated psums.

Source files
------------

// File: rtl/pe_mac_if.sv
// pe_mac_if: activation/weight input stream and partial-sum output stream of one MAC stage
interface pe_mac_if #(parameter int DATA_W = 8, parameter int PSUM_W = 16);
  logic in_valid;
  logic in_ready;
  logic signed [DATA_W-1:0] act_in;
  logic signed [DATA_W-1:0] wgt_in;
  logic out_valid;
  logic out_ready;
  logic signed [PSUM_W-1:0] psum_out;
  logic psum_sat;
  modport master (output in_valid, act_in, wgt_in, out_ready, input in_ready, out_valid, psum_out, psum_sat);
  modport slave (input in_valid, act_in, wgt_in, out_ready, output in_ready, out_valid, psum_out, psum_sat);
endinterface

// File: rtl/pe_mac_stream.sv
// pe_mac_stream: saturating KLEN-beat MAC window with a held output register feeding psum_accumulator
module pe_mac_stream #(
  parameter int DATA_W = 8,
  parameter int PSUM_W = 16,
  parameter int KLEN = 3
) (
  input logic clk,
  input logic rst,
  pe_mac_if.slave s
);
  localparam int CW = KLEN > 1 ? $clog2(KLEN) : 1;
  localparam logic [CW-1:0] LAST = CW'(KLEN - 1);
  logic signed [PSUM_W-1:0] acc, sat_val, psum;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [PSUM_W:0] sum;
  logic [CW-1:0] cnt;
  logic sat_acc, clamp, last, beat, ov, psat;
  always_comb begin
    prod = s.act_in * s.wgt_in;
    sum = (PSUM_W+1)'(acc) + (PSUM_W+1)'(prod);
    // one guard bit suffices: acc and prod both fit in PSUM_W signed bits
    clamp = sum[PSUM_W] != sum[PSUM_W-1];
    sat_val = clamp ? {sum[PSUM_W], {(PSUM_W-1){~sum[PSUM_W]}}} : sum[PSUM_W-1:0];
    last = cnt == LAST;
    beat = s.in_valid && s.in_ready;
  end
  assign s.in_ready = rst && !(ov && !s.out_ready && last);
  assign s.out_valid = ov;
  assign s.psum_out = psum;
  assign s.psum_sat = psat;
  always_ff @(posedge clk) begin
    if (!rst) begin
      acc <= '0;
      cnt <= '0;
      sat_acc <= 1'b0;
      ov <= 1'b0;
      psum <= '0;
      psat <= 1'b0;
    end else if (beat && last) begin
      psum <= sat_val;
      psat <= sat_acc | clamp;
      ov <= 1'b1;
      acc <= '0;
      sat_acc <= 1'b0;
      cnt <= '0;
    end else begin
      if (beat) begin
        acc <= sat_val;
        sat_acc <= sat_acc | clamp;
        cnt <= cnt + 1'b1;
      end
      if (ov && s.out_ready) ov <= 1'b0;
    end
  end
endmodule

// File: tb/tb_pe_mac_stream.sv
// tb_pe_mac_stream: directed window table, stall/reset sequences and a randomised saturating reference model
module tb_pe_mac_stream;
  logic clk, rst;
  int checks = 0, errors = 0;
  pe_mac_if #(.DATA_W(8), .PSUM_W(16)) bus();
  pe_mac_stream #(.DATA_W(8), .PSUM_W(16), .KLEN(3)) dut (.clk(clk), .rst(rst), .s(bus));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  typedef struct packed {
    logic [2:0][7:0] a;
    logic [2:0][7:0] w;
    int psum;
    logic sat;
  } win_t;
  typedef struct packed {
    int psum;
    logic sat;
  } res_t;
  win_t vec [5];
  res_t q [$];
  function automatic win_t mk(int a0, int a1, int a2, int w0, int w1, int w2, int p, logic st);
    win_t v;
    v.a = {8'(a2), 8'(a1), 8'(a0)};
    v.w = {8'(w2), 8'(w1), 8'(w0)};
    v.psum = p;
    v.sat = st;
    return v;
  endfunction
  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask
  task automatic drive(input logic v, input int a, input int w, input logic ordy);
    bus.in_valid = v;
    bus.act_in = 8'(a);
    bus.wgt_in = 8'(w);
    bus.out_ready = ordy;
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  function automatic logic signed [7:0] pick;
    int r;
    r = int'($urandom_range(5));
    return r == 0 ? -8'sd128 : r == 1 ? 8'sd127 : r == 2 ? -8'sd1 : r == 3 ? 8'sd0 : r == 4 ? 8'sd1 : 8'($urandom_range(255));
  endfunction
  initial begin
    int m_acc, m_cnt, got, cyc, s, er;
    logic m_sat, m_ov, b, c, oh;
    res_t r;
    vec[0] = mk(2, 4, 6, 5, 5, 5, 60, 1'b0);
    vec[1] = mk(127, 127, 127, 127, 127, 127, 32767, 1'b1);
    vec[2] = mk(1, 1, 1, 1, 1, 1, 3, 1'b0);
    vec[3] = mk(-128, -128, -128, 127, 127, 127, -32768, 1'b1);
    vec[4] = mk(-3, 5, 0, 4, 2, 9, -2, 1'b0);
    rst = 1'b0;
    drive(1'b1, 1, 1, 1'b1);
    #1;
    chk("rst_in_ready", int'(bus.in_ready), 0);
    step;
    step;
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_psum", int'(bus.psum_out), 0);
    chk("rst_sat", int'(bus.psum_sat), 0);
    rst = 1'b1;
    for (int i = 0; i < 5; i++)
      for (int k = 0; k < 3; k++) begin
        drive(1'b1, int'($signed(vec[i].a[k])), int'($signed(vec[i].w[k])), 1'b1);
        #1;
        chk("tbl_in_ready", int'(bus.in_ready), 1);
        step;
        chk("tbl_out_valid", int'(bus.out_valid), k == 2 ? 1 : 0);
        if (k == 2) begin
          chk("tbl_psum", int'(bus.psum_out), vec[i].psum);
          chk("tbl_sat", int'(bus.psum_sat), int'(vec[i].sat));
        end
      end
    drive(1'b0, 0, 0, 1'b1);
    step;
    chk("tbl_out_valid_drop", int'(bus.out_valid), 0);
    // held result: next window proceeds up to its last beat, then stalls
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 2 + 2 * k, 5, 1'b0);
      step;
    end
    chk("hold_psum", int'(bus.psum_out), 60);
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, 1, 1, 1'b0);
      #1;
      chk("hold_early_ready", int'(bus.in_ready), 1);
      step;
      chk("hold_keep_psum", int'(bus.psum_out), 60);
    end
    drive(1'b1, 1, 1, 1'b0);
    #1;
    chk("hold_stall", int'(bus.in_ready), 0);
    step;
    chk("hold_stall_valid", int'(bus.out_valid), 1);
    chk("hold_stall_psum", int'(bus.psum_out), 60);
    bus.out_ready = 1'b1;
    #1;
    chk("hold_release_ready", int'(bus.in_ready), 1);
    step;
    chk("hold_next_valid", int'(bus.out_valid), 1);
    chk("hold_next_psum", int'(bus.psum_out), 3);
    drive(1'b0, 0, 0, 1'b1);
    step;
    chk("hold_drain", int'(bus.out_valid), 0);
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 2, 5, 1'b0);
      step;
    end
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, 100, 100, 1'b0);
      step;
    end
    rst = 1'b0;
    drive(1'b1, 1, 1, 1'b1);
    #1;
    chk("mid_rst_in_ready", int'(bus.in_ready), 0);
    step;
    chk("mid_rst_out_valid", int'(bus.out_valid), 0);
    chk("mid_rst_psum", int'(bus.psum_out), 0);
    chk("mid_rst_sat", int'(bus.psum_sat), 0);
    step;
    rst = 1'b1;
    for (int k = 0; k < 3; k++) step;
    chk("post_rst_valid", int'(bus.out_valid), 1);
    chk("post_rst_psum", int'(bus.psum_out), 3);
    drive(1'b0, 0, 0, 1'b1);
    step;
    chk("post_rst_drain", int'(bus.out_valid), 0);
    m_acc = 0;
    m_cnt = 0;
    m_sat = 1'b0;
    m_ov = 1'b0;
    got = 0;
    cyc = 0;
    while (got < 200 && cyc < 20000) begin
      bus.in_valid = $urandom_range(3) != 0;
      bus.act_in = pick();
      bus.wgt_in = pick();
      bus.out_ready = $urandom_range(3) != 0;
      #1;
      er = (m_ov && !bus.out_ready && m_cnt == 2) ? 0 : 1;
      chk("rnd_in_ready", int'(bus.in_ready), er);
      chk("rnd_out_valid", int'(bus.out_valid), int'(m_ov));
      if (bus.out_valid && bus.out_ready) begin
        if (q.size() == 0) begin
          errors++;
          $display("FAIL rnd_extra_psum: got %0d expected none", int'(bus.psum_out));
        end else begin
          r = q.pop_front();
          chk("rnd_psum", int'(bus.psum_out), r.psum);
          chk("rnd_sat", int'(bus.psum_sat), int'(r.sat));
        end
        got++;
      end
      oh = m_ov && bus.out_ready;
      b = bus.in_valid && er == 1;
      c = 1'b0;
      if (b) begin
        s = m_acc + int'(bus.act_in) * int'(bus.wgt_in);
        c = s > 32767 || s < -32768;
        s = s > 32767 ? 32767 : s < -32768 ? -32768 : s;
        if (m_cnt == 2) begin
          r.psum = s;
          r.sat = m_sat | c;
          q.push_back(r);
          m_acc = 0;
          m_sat = 1'b0;
          m_cnt = 0;
        end else begin
          m_acc = s;
          m_sat = m_sat | c;
          m_cnt++;
        end
      end
      if (b && q.size() > 0 && m_cnt == 0) m_ov = 1'b1;
      else if (oh) m_ov = 1'b0;
      cyc++;
      step;
    end
    checks++;
    if (got < 200) begin
      errors++;
      $display("FAIL rnd_timeout: got %0d windows expected 200", got);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
